// File: rtl/jk_cnt_pkg.sv
// Shared types and JK drive encoding for the JK-cell modulo counter.
package jk_cnt_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_UP   = 2'b01,
    CNT_DOWN = 2'b10,
    CNT_LOAD = 2'b11
  } cnt_mode_e;

  // {j,k} pair encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Toggle is never requested; a bit either holds, sets or clears.
  function automatic logic [1:0] jk_drive(input logic cur, input logic nxt);
    if (cur == nxt) return JK_HOLD;
    else if (nxt)   return JK_SET;
    else            return JK_CLR;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable and synchronous active-high reset.
module jk_cell
  import jk_cnt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic ce_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ce_i) begin
      case ({j_i, k_i})
        JK_HOLD: q_d = q_q;
        JK_SET:  q_d = 1'b1;
        JK_CLR:  q_d = 1'b0;
        JK_TGL:  q_d = ~q_q;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= rst_val_i;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo up/down/load counter built from a bank of JK cells.
// Optional sticky overflow flag enabled by defining JK_CNT_OVF_STICKY_EN.
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2**WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("jk_mod_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("jk_mod_counter: RESET_VAL must be below MODULUS");
  end

  // One extra bit so MODULUS-1 = 2**WIDTH-1 compares without truncation
  localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE    = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);

  cnt_mode_e        mode;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   cnt_ext, ld_ext, nxt_ext;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             wrap_q;
  logic [1:0]       jk [WIDTH];
  logic             unused_top;

  assign mode    = cnt_mode_e'(mode_i);
  assign cnt_ext = {1'b0, cnt};
  assign ld_ext  = {1'b0, load_val_i};

  always_comb begin
    nxt_ext = cnt_ext;
    wrap_d  = 1'b0;
    if (en_i) begin
      case (mode)
        CNT_UP: begin
          if (cnt_ext >= MOD_M1) begin
            nxt_ext = '0;
            wrap_d  = (cnt_ext == MOD_M1);
          end else begin
            nxt_ext = cnt_ext + ONE;
          end
        end
        CNT_DOWN: begin
          if (cnt_ext == '0) begin
            nxt_ext = MOD_M1;
            wrap_d  = 1'b1;
          end else if (cnt_ext > MOD_M1) begin
            nxt_ext = '0;
          end else begin
            nxt_ext = cnt_ext - ONE;
          end
        end
        CNT_LOAD: nxt_ext = (ld_ext > MOD_M1) ? MOD_M1 : ld_ext;
        default:  nxt_ext = cnt_ext;
      endcase
    end
  end

  assign count_d    = nxt_ext[WIDTH-1:0];
  assign unused_top = nxt_ext[WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jk[i] = jk_drive(cnt[i], count_d[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rst_val_i (RST_V[g]),
      .ce_i      (en_i),
      .j_i       (jk[g][1]),
      .k_i       (jk[g][0]),
      .q_o       (cnt[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

`ifdef JK_CNT_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (en_i && mode == CNT_LOAD) ovf_d = 1'b0;
    else if (wrap_d)              ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign q_o    = cnt;
  assign wrap_o = wrap_q;
  assign tc_o   = en_i && (((mode == CNT_UP) && (cnt_ext == MOD_M1)) ||
                           ((mode == CNT_DOWN) && (cnt_ext == '0)));

endmodule
